// File: rtl/seq_alu.sv
// Registered ALU with a multi-cycle unsigned shift-add multiplier.
// Single-cycle ops complete one clock after START; MUL takes WIDTH clocks.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  input  logic             SC_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             SC_OUT,
  output logic             ZERO,
  output logic             BEVEN
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LSH = 3'd1,
    OP_RSH = 3'd2,
    OP_XOR = 3'd3,
    OP_AND = 3'd4,
    OP_SUB = 3'd5,
    OP_MUL = 3'd6,
    OP_NOP = 3'd7
  } op_t;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t             state, state_next;
  op_t                op;
  logic               accept;
  logic               finish;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  assign op = op_t'(OP);

  // Multiplier partial-product step: add the shifted multiplicand when the current B bit is set.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // BUSY covers the MUL cycles after the first one; the cycle right after START still ignores
  // new requests because the state is already MUL_RUN.
  assign BUSY = (state == MUL_RUN) && (cnt != '0);

  // Single-cycle datapath: result and shift/carry-out for every non-MUL opcode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    alu_lo = '0;
    alu_c  = 1'b0;
    sum    = '0;
    case (op)
      OP_ADD: begin
        sum             = {1'b0, INPUTA} + {1'b0, INPUTB} + (WIDTH+1)'(SC_IN);
        {alu_c, alu_lo} = sum;
      end
      OP_SUB: begin
        sum             = {1'b0, INPUTA} + {1'b0, ~INPUTB} + (WIDTH+1)'(SC_IN);
        {alu_c, alu_lo} = sum;
      end
      OP_LSH:  {alu_c, alu_lo} = {INPUTA, SC_IN};
      OP_RSH:  {alu_lo, alu_c} = {SC_IN, INPUTA};
      OP_XOR:  alu_lo = INPUTA ^ INPUTB;
      OP_AND:  alu_lo = INPUTA & INPUTB;
      default: alu_lo = '0;
    endcase
  end

  // Next-state logic: decide whether a request is accepted and when a MUL completes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          if (op == OP_MUL) state_next = MUL_RUN;
          else              accept     = 1'b1;
        end
      end
      MUL_RUN: begin
        if (cnt == CW'(WIDTH-1)) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // Multiplier iteration registers and result/flag registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      DONE   <= 1'b0;
      OUT    <= '0;
      OUT_HI <= '0;
      SC_OUT <= 1'b0;
      ZERO   <= 1'b0;
      BEVEN  <= 1'b0;
    end else begin
      DONE <= accept | finish;

      if (state == IDLE && START && op == OP_MUL) begin
        mcand  <= {{WIDTH{1'b0}}, INPUTA};
        mplier <= INPUTB;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == MUL_RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end

      if (accept) begin
        OUT    <= alu_lo;
        OUT_HI <= '0;
        SC_OUT <= alu_c;
        ZERO   <= (alu_lo == '0);
        BEVEN  <= ~alu_lo[0];
      end else if (finish) begin
        {OUT_HI, OUT} <= acc_next;
        SC_OUT        <= 1'b0;
        ZERO          <= (acc_next == '0);
        BEVEN         <= ~acc_next[0];
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START;
  logic [2:0] OP;
  logic [7:0] INPUTA, INPUTB;
  logic       SC_IN;
  logic       BUSY, DONE, SC_OUT, ZERO, BEVEN;
  logic [7:0] OUT, OUT_HI;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP),
    .INPUTA(INPUTA), .INPUTB(INPUTB), .SC_IN(SC_IN),
    .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .OUT_HI(OUT_HI),
    .SC_OUT(SC_OUT), .ZERO(ZERO), .BEVEN(BEVEN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present one request, let one rising edge sample it, return at the following falling edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sc);
    OP = op; INPUTA = a; INPUTB = b; SC_IN = sc; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    RESET_N = 1'b0; START = 1'b0; OP = 3'd7; INPUTA = 8'h00; INPUTB = 8'h00; SC_IN = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 16'(BUSY), 16'h0);
    check("rst_done", 16'(DONE), 16'h0);
    check("rst_out", {OUT_HI, OUT}, 16'h0000);
    check("rst_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'h0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("idle_done", 16'(DONE), 16'h0);

    // ADD B3+4D+1 = 0x101
    issue(3'd0, 8'hB3, 8'h4D, 1'b1);
    check("add_done", 16'(DONE), 16'h1);
    check("add_out", 16'(OUT), 16'h01);
    check("add_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'b100);
    check("add_hi", 16'(OUT_HI), 16'h00);

    // Back-to-back SUBs: DONE stays high each cycle.
    issue(3'd5, 8'h07, 8'h05, 1'b1);
    check("sub1_out", {7'h0, SC_OUT, OUT}, {7'h0, 1'b1, 8'h02});
    issue(3'd5, 8'h05, 8'h07, 1'b1);
    check("sub2_done", 16'(DONE), 16'h1);
    check("sub2_out", {7'h0, SC_OUT, OUT}, {7'h0, 1'b0, 8'hFE});

    issue(3'd1, 8'hB3, 8'h00, 1'b1);
    check("lsh_out", {7'h0, SC_OUT, OUT}, {7'h0, 1'b1, 8'h67});
    issue(3'd2, 8'hB3, 8'h00, 1'b0);
    check("rsh_out", {7'h0, SC_OUT, OUT}, {7'h0, 1'b1, 8'h59});
    @(negedge CLK);
    check("idle_done2", 16'(DONE), 16'h0);
    check("hold_out", 16'(OUT), 16'h59);

    // MUL FF*FF with an ADD request pulsed while it runs.
    issue(3'd6, 8'hFF, 8'hFF, 1'b0);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        OP = 3'd0; INPUTA = 8'h01; INPUTB = 8'h01; START = 1'b1;
      end else begin
        START = 1'b0;
        INPUTA = 8'h12; INPUTB = 8'h34;
      end
      @(negedge CLK);
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end else if (done_cnt == 0) begin
        check("mul_hold", 16'(OUT), 16'h59);
      end
    end
    START = 1'b0;
    check("mul_busy_cycles", 16'(busy_cnt), 16'd7);
    check("mul_done_at", 16'(done_at), 16'd8);
    check("mul_done_count", 16'(done_cnt), 16'd1);
    check("mul_product", {OUT_HI, OUT}, 16'hFE01);
    check("mul_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'b000);

    // Non-MUL op clears the high half.
    issue(3'd4, 8'hF0, 8'h3C, 1'b1);
    check("and_out", {OUT_HI, OUT}, 16'h0030);
    check("and_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'b001);

    // MUL aborted by reset at the 4th cycle.
    issue(3'd6, 8'h0F, 8'h0F, 1'b0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    check("abort_out", {OUT_HI, OUT}, 16'h0000);
    check("abort_flags", {12'h0, BUSY, SC_OUT, ZERO, BEVEN}, 16'h0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      check("abort_busy", 16'(BUSY), 16'h0);
      if (DONE) done_cnt++;
      @(negedge CLK);
    end
    check("abort_no_done", 16'(done_cnt), 16'd0);
    issue(3'd0, 8'h01, 8'h01, 1'b0);
    check("post_abort_add", {7'h0, DONE, OUT}, {7'h0, 1'b1, 8'h02});

    issue(3'd3, 8'h5A, 8'h5A, 1'b0);
    check("xor_out", 16'(OUT), 16'h00);
    check("xor_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'b011);
    issue(3'd7, 8'hAA, 8'h55, 1'b1);
    check("nop_out", {7'h0, DONE, OUT}, {7'h0, 1'b1, 8'h00});
    check("nop_flags", {13'h0, SC_OUT, ZERO, BEVEN}, 16'b011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
